// File: rtl/hazard_pkg.sv
// Shared types for the hazard/fetch controller.
//   HAZ_LAT_DEF : default cycles from issue until a destination is readable in ID
//   sb_cnt_t    : per-register scoreboard countdown (holds 0..3)
//   pc_sel_e    : source of the next PC
package hazard_pkg;

    localparam int HAZ_LAT_DEF = 3;

    typedef logic [1:0] sb_cnt_t;

    typedef enum logic [1:0] {
        PC_INC,
        PC_HOLD,
        PC_REDIR
    } pc_sel_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Register scoreboard: one countdown per architectural register x1..x31.
// Ports:
//   i_clk, i_rst       clock, synchronous active-low reset
//   i_set_en, i_set_rd load HAZ_LAT into the counter of i_set_rd on the next edge
//   i_rs1, i_rs2       query indices
//   o_rs1_busy/rs2     combinational: queried register still has a write in flight
module reg_scoreboard
    import hazard_pkg::*;
#(
    parameter int HAZ_LAT = HAZ_LAT_DEF
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_set_en,
    input  logic [4:0] i_set_rd,
    input  logic [4:0] i_rs1,
    input  logic [4:0] i_rs2,
    output logic       o_rs1_busy,
    output logic       o_rs2_busy
);

    // Entry 0 exists only so the query ports can index directly; it stays 0,
    // which makes x0 permanently not busy.
    sb_cnt_t cnt [0:31];

    always_ff @(posedge i_clk) begin
        cnt[0] <= '0;
        for (int r = 1; r < 32; r++) begin
            if (!i_rst) begin
                cnt[r] <= '0;
            end else if (i_set_en && (i_set_rd == 5'(r))) begin
                // A new producer overrides whatever countdown was in progress.
                cnt[r] <= sb_cnt_t'(HAZ_LAT);
            end else if (cnt[r] != '0) begin
                cnt[r] <= cnt[r] - 2'd1;
            end
        end
    end

    assign o_rs1_busy = (cnt[i_rs1] != '0);
    assign o_rs2_busy = (cnt[i_rs2] != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and fetch controller for the non-forwarding 5-stage core.
// Chooses the next PC (increment, hold, redirect) and drives stall/flush
// strobes for IF/ID and ID/EX; counts stalled cycles.
// Ports:
//   i_clk, i_rst              clock, synchronous active-low reset
//   i_pc, i_imem_ready        current PC and fetch-data valid
//   i_id_*                    decoded ID-stage operand/destination info
//   i_ex_redirect/_target     taken branch/jump resolved in EX
//   o_pc_next                 combinational next PC
//   o_stall_pc/_if_id         hold strobes
//   o_flush_if_id/_id_ex      bubble strobes
//   o_issue                   ID instruction moves to EX this cycle
//   o_stall_cnt               wrapping count of cycles with o_stall_pc high
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int HAZ_LAT = HAZ_LAT_DEF,
    parameter int XLEN    = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_imem_ready,
    input  logic            i_id_valid,
    input  logic [4:0]      i_id_rs1,
    input  logic [4:0]      i_id_rs2,
    input  logic            i_id_rs1_used,
    input  logic            i_id_rs2_used,
    input  logic [4:0]      i_id_rd,
    input  logic            i_id_rd_wen,
    input  logic            i_ex_redirect,
    input  logic [XLEN-1:0] i_ex_target,
    output logic [XLEN-1:0] o_pc_next,
    output logic            o_stall_pc,
    output logic            o_stall_if_id,
    output logic            o_flush_if_id,
    output logic            o_flush_id_ex,
    output logic            o_issue,
    output logic [31:0]     o_stall_cnt
);

    logic    rs1_busy;
    logic    rs2_busy;
    logic    haz;
    logic    set_en;
    pc_sel_e pc_sel;

    assign set_en = o_issue && i_id_rd_wen && (i_id_rd != 5'd0);

    reg_scoreboard #(.HAZ_LAT(HAZ_LAT)) u_sb (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_set_en   (set_en),
        .i_set_rd   (i_id_rd),
        .i_rs1      (i_id_rs1),
        .i_rs2      (i_id_rs2),
        .o_rs1_busy (rs1_busy),
        .o_rs2_busy (rs2_busy)
    );

    assign haz = i_id_valid && ((i_id_rs1_used && rs1_busy) ||
                                (i_id_rs2_used && rs2_busy));

    // Priority: reset > redirect > fetch wait / data hazard > normal flow.
    always_comb begin
        pc_sel        = PC_INC;
        o_stall_pc    = 1'b0;
        o_stall_if_id = 1'b0;
        o_flush_if_id = 1'b0;
        o_flush_id_ex = 1'b0;
        o_issue       = 1'b0;
        if (!i_rst) begin
            pc_sel = PC_INC;
        end else if (i_ex_redirect) begin
            // Wrong-path instructions in IF and ID are discarded.
            pc_sel        = PC_REDIR;
            o_flush_if_id = 1'b1;
            o_flush_id_ex = 1'b1;
        end else if (!i_imem_ready || haz) begin
            pc_sel        = PC_HOLD;
            o_stall_pc    = 1'b1;
            o_stall_if_id = 1'b1;
            o_flush_id_ex = 1'b1;
        end else begin
            o_issue = i_id_valid;
        end
    end

    always_comb begin
        case (pc_sel)
            PC_REDIR: o_pc_next = i_ex_target;
            PC_HOLD:  o_pc_next = i_pc;
            default:  o_pc_next = i_pc + XLEN'(4);
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            o_stall_cnt <= '0;
        end else if (o_stall_pc) begin
            o_stall_cnt <= o_stall_cnt + 32'd1;
        end
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and fetch controller for the non-forwarding 5-stage core. It decides each cycle whether the program counter advances, holds or redirects, and drives the stall and flush strobes for the IF/ID and ID/EX registers. A register scoreboard tracks in-flight destinations so dependent instructions wait in ID until the producing write has landed in the register file. It sits beside the `pc` register and drives its `stall_pc` and `pc_next` inputs.

## Interface

- `HAZ_LAT`, 3, cycles from issue until a destination register is readable in ID (no forwarding); legal range 1–3.
- `XLEN`, 32, address width.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst`  in  1  reset; synchronous, active-low.
- `i_pc`  in  XLEN  current PC (from `pc`).
- `i_imem_ready`  in  1  instruction memory has valid data for `i_pc` this cycle.
- `i_id_valid`  in  1  ID holds a real instruction.
- `i_id_rs1`, `i_id_rs2`  in  5  ID source register indices.
- `i_id_rs1_used`, `i_id_rs2_used`  in  1  source actually read.
- `i_id_rd`  in  5  ID destination index.
- `i_id_rd_wen`  in  1  ID instruction writes `rd`.
- `i_ex_redirect`  in  1  EX resolved a taken branch or jump.
- `i_ex_target`  in  XLEN  redirect target.
- `o_pc_next`  out  XLEN  next PC; combinational.
- `o_stall_pc`  out  1  hold PC.
- `o_stall_if_id`  out  1  hold IF/ID.
- `o_flush_if_id`  out  1  clear IF/ID to a bubble.
- `o_flush_id_ex`  out  1  insert a bubble into ID/EX.
- `o_issue`  out  1  ID instruction advances to EX this cycle.
- `o_stall_cnt`  out  32  count of cycles with `o_stall_pc` high; reset 0; wraps.

## Operation

**Scoreboard**
- One `HAZ_LAT`-range counter for each of registers 1–31. Register x0 is never tracked and never causes a hazard.
- Each nonzero counter decrements once per cycle.
- When `o_issue` is high and `i_id_rd_wen` is high and `i_id_rd` is nonzero, the counter for `rd` loads `HAZ_LAT` on the next edge. If a decrement of the same entry happens in the same cycle, the load wins.

**Hazard detection**
- `haz` = `i_id_valid` && ((`rs1_used` && cnt[rs1] != 0) || (`rs2_used` && cnt[rs2] != 0)).
- This is combinational from the current counter values.

**Priority, evaluated each cycle**
- Redirect (`i_ex_redirect`):
  - `o_pc_next` = `i_ex_target`.
  - `o_flush_if_id` = 1, `o_flush_id_ex` = 1.
  - `o_stall_pc` = 0, `o_issue` = 0.
  - Overrides every stall.
- Fetch wait (`!i_imem_ready`):
  - `o_stall_pc` = 1, `o_stall_if_id` = 1.
  - `o_flush_id_ex` = 1, `o_issue` = 0.
- Data hazard (`haz`):
  - `o_stall_pc` = 1, `o_stall_if_id` = 1.
  - `o_flush_id_ex` = 1, `o_issue` = 0.
- Otherwise:
  - `o_pc_next` = `i_pc` + 4.
  - `o_issue` = `i_id_valid`.
  - All stall and flush outputs = 0.

**Reset**
- While `i_rst` = 0, all scoreboard counters and `o_stall_cnt` clear on the edge.
- All strobe outputs are forced to 0 during reset.
- `o_pc_next` remains `i_pc` + 4. The PC reset itself is handled by `pc`.

## Timing

- Issue at cycle t with `rd` = 5: a consumer of x5 sitting in ID at t+1 stalls for exactly `HAZ_LAT` cycles (t+1 … t+`HAZ_LAT`) and issues at t+`HAZ_LAT`+1.
- A consumer arriving k cycles after the producer stalls max(0, `HAZ_LAT`−k+1) cycles.
- Stall and flush strobes are combinational from the inputs and current state: zero latency, effective at the next edge.
- A redirect during an active hazard stall drops the stalled ID instruction. No scoreboard entry is created for it; existing entries keep counting down.
- A redirect and fetch wait in the same cycle: redirect wins. Fetch wait then applies from the next cycle at the new PC.
- Reset asserted mid-stall clears all counters. After reset is released, no stale hazards remain.

## Structure

- `hazard_pkg`:
  - `HAZ_LAT` default.
  - `sb_cnt_t` (2-bit counter type).
  - `pc_sel_e` {`PC_INC`, `PC_HOLD`, `PC_REDIR`}.
- One sub-module, `reg_scoreboard`:
  - Inputs: set port (`rd`, enable).
  - Outputs: two combinational busy-query ports (`rs1`, `rs2`).
  - Owns the 31 counters.
- `hazard_ctrl` contains only the priority logic and the stall counter.

## Test plan

- Back-to-back RAW: issue `add x5` (wen) at t, then `sub` reading rs1 = x5 → `o_stall_pc` high for cycles t+1..t+3, `o_issue` at t+4, `o_stall_cnt` = 3.
- x0 destination: producer writes x0, consumer reads x0 → no stall, `o_issue` on every cycle.
- Redirect during a hazard stall: `i_ex_redirect` = 1 with target 0x100 at t+2 → `o_pc_next` = 0x100, both flushes high, `o_stall_pc` = 0. The x5 counter keeps decrementing to 0 by t+3.
- Fetch wait: `i_imem_ready` = 0 for 2 cycles with no hazard → `o_stall_pc` and `o_flush_id_ex` high for 2 cycles, `o_issue` = 0, PC unchanged.
- Reissue collision: x5 counter at 1 while a new x5 producer issues → counter reloads to 3, not 0.
- Reset mid-stall: drop `i_rst` at t+1 of a hazard stall → the next cycle after release has no stall, and `o_stall_cnt` = 0.
